// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Decode-side hazard controller. It inserts load-use bubbles,
//               flushes on taken branches and expands vector column writes
//               into NUM_COLS back-to-back ID/EX issues.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int          NUM_COLS  = 4,
    parameter int          REG_AW    = 5,
    parameter logic [1:0]  LOAD_CODE = 2'b01,
    parameter int          CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ID_valid,
    input  logic [REG_AW-1:0]             ID_rs1,
    input  logic [REG_AW-1:0]             ID_rs2,
    input  logic                          ID_colwrite_req,
    input  logic [REG_AW-1:0]             EX_rd,
    input  logic                          EX_RegWrite,
    input  logic [1:0]                    EX_MemToReg,
    input  logic                          branch_taken,
    output logic                          pc_stall,
    output logic                          ifid_stall,
    output logic                          ifid_flush,
    output logic                          idex_flush,
    output logic                          ID_colwrite,
    output logic [$clog2(NUM_COLS)-1:0]   ID_columna,
    output logic                          col_done,
    output logic [CNT_W-1:0]              stall_cycles
);

    localparam int                   c_COL_W    = $clog2(NUM_COLS);
    localparam logic [c_COL_W-1:0]   c_LAST_COL = c_COL_W'(NUM_COLS - 1);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_LU_BUBBLE = 2'd1;
    localparam logic [1:0] c_ST_COL_SEQ   = 2'd2;

    logic [1:0]         r_state;
    logic [c_COL_W-1:0] r_col_cnt;
    logic [CNT_W-1:0]   r_stall_cycles;

    logic [1:0]         w_state_nxt;
    logic [c_COL_W-1:0] w_col_cnt_nxt;
    logic               w_load_use;
    logic               w_col_start;
    logic               w_pc_stall;
    logic               w_ifid_stall;
    logic               w_ifid_flush;
    logic               w_idex_flush;
    logic               w_colwrite;
    logic [c_COL_W-1:0] w_columna;
    logic               w_col_done;

    assign w_load_use = ID_valid & EX_RegWrite & (EX_MemToReg == LOAD_CODE) &
                        (EX_rd != '0) & ((EX_rd == ID_rs1) | (EX_rd == ID_rs2));
    assign w_col_start = ID_valid & ID_colwrite_req;

    always_comb begin
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_colwrite    = 1'b0;
        w_columna     = '0;
        w_col_done    = 1'b0;
        w_state_nxt   = r_state;
        w_col_cnt_nxt = r_col_cnt;

        if (branch_taken) begin
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_state_nxt   = c_ST_IDLE;
            w_col_cnt_nxt = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_load_use) begin
                        w_pc_stall   = 1'b1;
                        w_ifid_stall = 1'b1;
                        w_idex_flush = 1'b1;
                        w_state_nxt  = c_ST_LU_BUBBLE;
                    end else if (w_col_start) begin
                        w_colwrite    = 1'b1;
                        w_pc_stall    = 1'b1;
                        w_ifid_stall  = 1'b1;
                        w_col_cnt_nxt = c_COL_W'(1);
                        w_state_nxt   = c_ST_COL_SEQ;
                    end
                end
                // EX holds the bubble just inserted, so the hazard cannot recur here
                c_ST_LU_BUBBLE: begin
                    if (w_col_start) begin
                        w_colwrite    = 1'b1;
                        w_pc_stall    = 1'b1;
                        w_ifid_stall  = 1'b1;
                        w_col_cnt_nxt = c_COL_W'(1);
                        w_state_nxt   = c_ST_COL_SEQ;
                    end else begin
                        w_state_nxt   = c_ST_IDLE;
                    end
                end
                c_ST_COL_SEQ: begin
                    w_colwrite = 1'b1;
                    w_columna  = r_col_cnt;
                    if (r_col_cnt == c_LAST_COL) begin
                        w_col_done    = 1'b1;
                        w_col_cnt_nxt = '0;
                        w_state_nxt   = c_ST_IDLE;
                    end else begin
                        w_pc_stall    = 1'b1;
                        w_ifid_stall  = 1'b1;
                        w_col_cnt_nxt = r_col_cnt + c_COL_W'(1);
                    end
                end
                default: begin
                    w_state_nxt   = c_ST_IDLE;
                    w_col_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Reset masks every control so the pipeline registers stay quiet while held
    assign pc_stall     = w_pc_stall   & ~rst;
    assign ifid_stall   = w_ifid_stall & ~rst;
    assign ifid_flush   = w_ifid_flush & ~rst;
    assign idex_flush   = w_idex_flush & ~rst;
    assign ID_colwrite  = w_colwrite   & ~rst;
    assign col_done     = w_col_done   & ~rst;
    assign ID_columna   = rst ? '0 : w_columna;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_col_cnt      <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_col_cnt <= w_col_cnt_nxt;
            if (w_pc_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed and randomized bench for pipe_hazard_ctrl against a
//               cycle-level behavioural model of the hazard rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int c_N     = 4;
    localparam int c_AW    = 5;
    localparam int c_CNT_W = 16;
    localparam int c_SAT   = 65535;

    logic             clk;
    logic             rst;
    logic             ID_valid;
    logic [c_AW-1:0]  ID_rs1;
    logic [c_AW-1:0]  ID_rs2;
    logic             ID_colwrite_req;
    logic [c_AW-1:0]  EX_rd;
    logic             EX_RegWrite;
    logic [1:0]       EX_MemToReg;
    logic             branch_taken;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_flush;
    logic             ID_colwrite;
    logic [1:0]       ID_columna;
    logic             col_done;
    logic [c_CNT_W-1:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: index of the next column to issue (-1 when no sequence is active),
    // whether EX holds a load-use bubble, and the expected stall count.
    int m_col    = -1;
    bit m_bubble = 1'b0;
    int m_stalls = 0;

    pipe_hazard_ctrl #(
        .NUM_COLS  (c_N),
        .REG_AW    (c_AW),
        .LOAD_CODE (2'b01),
        .CNT_W     (c_CNT_W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .ID_valid        (ID_valid),
        .ID_rs1          (ID_rs1),
        .ID_rs2          (ID_rs2),
        .ID_colwrite_req (ID_colwrite_req),
        .EX_rd           (EX_rd),
        .EX_RegWrite     (EX_RegWrite),
        .EX_MemToReg     (EX_MemToReg),
        .branch_taken    (branch_taken),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .ID_colwrite     (ID_colwrite),
        .ID_columna      (ID_columna),
        .col_done        (col_done),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input bit r, input bit v, input int rs1, input int rs2, input bit req,
                          input int rd, input bit rw, input logic [1:0] mtr, input bit br);
        rst             = r;
        ID_valid        = v;
        ID_rs1          = c_AW'(rs1);
        ID_rs2          = c_AW'(rs2);
        ID_colwrite_req = req;
        EX_rd           = c_AW'(rd);
        EX_RegWrite     = rw;
        EX_MemToReg     = mtr;
        branch_taken    = br;
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit hz, lu, e_ps, e_ifl, e_xfl, e_cw, e_done;
        int e_col;
        @(negedge clk);
        hz = ID_valid && EX_RegWrite && (EX_MemToReg == 2'b01) && (EX_rd != 0) &&
             ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));
        lu = hz && !m_bubble && (m_col < 0);
        e_ps = 0; e_ifl = 0; e_xfl = 0; e_cw = 0; e_done = 0; e_col = 0;
        if (rst) begin
        end else if (branch_taken) begin
            e_ifl = 1; e_xfl = 1;
        end else if (m_col >= 0) begin
            e_cw = 1; e_col = m_col;
            e_ps = (m_col < c_N - 1);
            e_done = (m_col == c_N - 1);
        end else if (lu) begin
            e_ps = 1; e_xfl = 1;
        end else if (ID_valid && ID_colwrite_req) begin
            e_cw = 1; e_ps = 1;
        end
        chk("ctrl", {26'd0, pc_stall, ifid_stall, ifid_flush, idex_flush, ID_colwrite, col_done},
            {26'd0, e_ps, e_ps, e_ifl, e_xfl, e_cw, e_done});
        chk("columna", {30'd0, ID_columna}, e_col);
        chk("stall_cycles", {16'd0, stall_cycles}, m_stalls);
        @(posedge clk);
        if (rst) begin
            m_col = -1; m_bubble = 0; m_stalls = 0;
        end else begin
            if (e_ps && m_stalls < c_SAT) m_stalls++;
            if (branch_taken) begin
                m_col = -1; m_bubble = 0;
            end else if (m_col >= 0) begin
                m_col = (m_col == c_N - 1) ? -1 : m_col + 1;
                m_bubble = 0;
            end else if (lu) begin
                m_bubble = 1;
            end else if (ID_valid && ID_colwrite_req) begin
                m_col = 1; m_bubble = 0;
            end else begin
                m_bubble = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        cycle();
        idle_in();
    endtask

    initial begin
        idle_in();
        rst = 1;
        cycle();
        cycle();
        idle_in();
        chk("reset_stall_cycles", {16'd0, stall_cycles}, 0);

        // Load-use on rs2: one stall cycle, then the bubble cycle
        set_in(0, 1, 7, 5, 0, 5, 1, 2'b01, 0);
        cycle();
        cycle();
        idle_in();
        cycle();
        chk("lu_stall_total", {16'd0, stall_cycles}, 1);

        // No false hazards: x0 load, and non-load writer
        set_in(0, 1, 0, 9, 0, 0, 1, 2'b01, 0);
        cycle();
        cycle();
        set_in(0, 1, 5, 9, 0, 5, 1, 2'b00, 0);
        cycle();
        cycle();
        chk("no_false_hazard", {16'd0, stall_cycles}, 1);

        // Full column sequence
        do_reset();
        set_in(0, 1, 0, 0, 1, 0, 0, 2'b00, 0);
        repeat (c_N) cycle();
        idle_in();
        cycle();
        chk("col_seq_stalls", {16'd0, stall_cycles}, c_N - 1);

        // Branch during column 1 aborts the sequence
        do_reset();
        set_in(0, 1, 0, 0, 1, 0, 0, 2'b00, 0);
        cycle();
        branch_taken = 1;
        cycle();
        idle_in();
        cycle();
        chk("branch_abort_stalls", {16'd0, stall_cycles}, 1);
        chk("branch_abort_idle", {31'd0, ID_colwrite}, 0);

        // Load-use with a column write behind it
        do_reset();
        set_in(0, 1, 3, 0, 1, 3, 1, 2'b01, 0);
        repeat (c_N + 1) cycle();
        idle_in();
        cycle();
        chk("lu_then_col_stalls", {16'd0, stall_cycles}, c_N);

        // Reset during column 2
        do_reset();
        set_in(0, 1, 0, 0, 1, 0, 0, 2'b00, 0);
        cycle();
        cycle();
        rst = 1;
        cycle();
        idle_in();
        cycle();
        chk("mid_seq_reset_cnt", {16'd0, stall_cycles}, 0);
        chk("mid_seq_reset_done", {31'd0, col_done}, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 63) == 0);
            branch_taken    = ($urandom_range(0, 7) == 0);
            ID_valid        = ($urandom_range(0, 9) != 0);
            ID_colwrite_req = ($urandom_range(0, 3) == 0);
            ID_rs1          = c_AW'($urandom_range(0, 3));
            ID_rs2          = c_AW'($urandom_range(0, 3));
            EX_rd           = c_AW'($urandom_range(0, 3));
            EX_RegWrite     = ($urandom_range(0, 9) < 7);
            EX_MemToReg     = $urandom_range(0, 1) ? 2'b01 : 2'($urandom_range(0, 3));
            cycle();
        end

        // Saturation: load-use plus column pattern stalls 4 of every 5 cycles
        do_reset();
        set_in(0, 1, 3, 0, 1, 3, 1, 2'b01, 0);
        repeat (82000) cycle();
        idle_in();
        cycle();
        chk("stall_saturate", {16'd0, stall_cycles}, 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
